// File: rtl/shift_add_multiplier_param_if.sv
// Operand/control/result bundle for the shift-add multiplier.
// The master side drives operands and requests; the slave side returns status and product.
interface shift_add_multiplier_param_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               load_a;
  logic               load_b;
  logic               sgn;
  logic               start;
  logic [2*WIDTH-1:0] p;
  logic               busy;
  logic               done;

  modport master (
    output a, b, load_a, load_b, sgn, start,
    input  p, busy, done
  );

  modport slave (
    input  a, b, load_a, load_b, sgn, start,
    output p, busy, done
  );
endinterface

// File: rtl/shift_add_multiplier_param.sv
// Sequential shift-and-add multiplier, one partial product per clock, WIDTH cycles per product.
// Signed mode multiplies magnitudes and negates the result when the operand signs differ.
module shift_add_multiplier_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic                       clk_10kHz,
  input  logic                       clrn,
  shift_add_multiplier_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     reg_a, reg_b;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   mcand_q, acc_q, acc_sum;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 start_d, sgn_q;
  logic                 start_edge, capture, accept, last;

  assign start_edge = bus.start & ~start_d;

  // -x in WIDTH bits maps -2**(WIDTH-1) onto itself, which read unsigned is the right magnitude
  assign mag_a   = (bus.sgn && reg_a[WIDTH-1]) ? -reg_a : reg_a;
  assign mag_b   = (bus.sgn && reg_b[WIDTH-1]) ? -reg_b : reg_b;
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);

  always_ff @(posedge clk_10kHz or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    accept  = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        // a load wins over a coincident start; that start is dropped, not queued
        if (bus.load_a || bus.load_b) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (start_edge) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_10kHz or negedge clrn) begin
    if (!clrn) begin
      start_d  <= 1'b0;
      sgn_q    <= 1'b0;
      reg_a    <= '0;
      reg_b    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      bus.p    <= '0;
    end else begin
      start_d <= bus.start;
      if (capture) begin
        if (bus.load_a) reg_a <= bus.a;
        if (bus.load_b) reg_b <= bus.b;
      end
      if (accept) begin
        sgn_q    <= bus.sgn;
        mcand_q  <= {{WIDTH{1'b0}}, mag_a};
        mplier_q <= mag_b;
        acc_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == CALC) begin
        acc_q    <= acc_sum;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        // operand registers are frozen during CALC, so their sign bits are still valid here
        if (last) begin
          bus.p <= (sgn_q && (reg_a[WIDTH-1] ^ reg_b[WIDTH-1])) ? -acc_sum : acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_param.sv
// Scoreboard bench for shift_add_multiplier_param at WIDTH=8 and WIDTH=4.
module tb_shift_add_multiplier_param;

  logic clk  = 1'b0;
  logic clrn = 1'b1;
  int   checks = 0;
  int   passes = 0;

  logic [15:0] q8[$];
  logic [15:0] q4[$];
  logic [15:0] e8, e4;
  logic        done8_q = 1'b0;
  logic        done4_q = 1'b0;

  always #5 clk = ~clk;

  shift_add_multiplier_param_if #(.WIDTH(8)) bus8 ();
  shift_add_multiplier_param_if #(.WIDTH(4)) bus4 ();

  shift_add_multiplier_param #(.WIDTH(8), .CNT_W(5)) dut8 (
    .clk_10kHz(clk), .clrn(clrn), .bus(bus8)
  );
  shift_add_multiplier_param #(.WIDTH(4), .CNT_W(3)) dut4 (
    .clk_10kHz(clk), .clrn(clrn), .bus(bus4)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_in(input int sel, input logic [7:0] va, input logic [7:0] vb,
                        input logic la, input logic lb, input logic s, input logic st);
    if (sel == 8) begin
      bus8.a = va; bus8.b = vb; bus8.load_a = la; bus8.load_b = lb;
      bus8.sgn = s; bus8.start = st;
    end else begin
      bus4.a = va[3:0]; bus4.b = vb[3:0]; bus4.load_a = la; bus4.load_b = lb;
      bus4.sgn = s; bus4.start = st;
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 8) ? bus8.busy : bus4.busy;
  endfunction

  function automatic logic done_of(input int sel);
    return (sel == 8) ? bus8.done : bus4.done;
  endfunction

  task automatic push(input int sel, input logic [15:0] v);
    if (sel == 8) q8.push_back(v);
    else          q4.push_back(v);
  endtask

  // counts busy cycles until done, bounded so a stuck DUT still reaches the summary
  task automatic wait_result(input int sel, input int exp_busy, input string name);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_of(sel)) n++;
      if (done_of(sel)) begin
        seen = 1;
        break;
      end
    end
    chk({name, " done seen"}, 32'(seen), 32'd1);
    chk({name, " busy cycles"}, 32'(n), 32'(exp_busy));
  endtask

  task automatic mult(input int sel, input logic [7:0] va, input logic [7:0] vb,
                      input logic s, input logic [15:0] expv, input string name);
    @(posedge clk); #1 set_in(sel, va, vb, 1, 1, s, 0);
    @(posedge clk); #1 set_in(sel, va, vb, 0, 0, s, 1);
    push(sel, expv);
    @(posedge clk); #1 set_in(sel, va, vb, 0, 0, s, 0);
    wait_result(sel, sel, name);
  endtask

  always @(negedge clk) begin
    if (bus8.done && !done8_q) begin
      if (q8.size() == 0) chk("w8 unexpected done", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("w8 p", 32'(bus8.p), 32'(e8));
        chk("w8 busy with done", 32'(bus8.busy), 32'd0);
      end
    end
    done8_q = bus8.done;
  end

  always @(negedge clk) begin
    if (bus4.done && !done4_q) begin
      if (q4.size() == 0) chk("w4 unexpected done", 32'd1, 32'd0);
      else begin
        e4 = q4.pop_front();
        chk("w4 p", 32'({8'h00, bus4.p}), 32'(e4));
        chk("w4 busy with done", 32'(bus4.busy), 32'd0);
      end
    end
    done4_q = bus4.done;
  end

  initial begin
    set_in(8, 8'd0, 8'd0, 0, 0, 0, 0);
    set_in(4, 8'd0, 8'd0, 0, 0, 0, 0);
    #1 clrn = 1'b0;
    #1;
    chk("reset w8 p", 32'(bus8.p), 32'd0);
    chk("reset w8 busy", 32'(bus8.busy), 32'd0);
    chk("reset w8 done", 32'(bus8.done), 32'd0);
    chk("reset w4 p", 32'(bus4.p), 32'd0);
    chk("reset w4 busy", 32'(bus4.busy), 32'd0);
    chk("reset w4 done", 32'(bus4.done), 32'd0);
    @(negedge clk);
    clrn = 1'b1;

    mult(4, 8'd15, 8'd15, 0, 16'd225, "w4 15x15");
    mult(4, 8'd0,  8'd9,  0, 16'd0,   "w4 0x9");
    mult(4, 8'h8,  8'h8,  1, 16'h40,  "w4 -8x-8");

    mult(8, 8'd62,  8'd3,  0, 16'd186,  "w8 62x3");
    mult(8, 8'hC2,  8'd3,  1, 16'hFF46, "w8 -62x3");
    mult(8, 8'h80,  8'h80, 1, 16'h4000, "w8 -128x-128");
    mult(8, 8'h00,  8'hFD, 1, 16'h0000, "w8 0x-3");

    // load_a during CALC must not disturb the running product or the stored operand
    @(posedge clk); #1 set_in(8, 8'd62, 8'd3, 1, 1, 0, 0);
    @(posedge clk); #1 set_in(8, 8'd62, 8'd3, 0, 0, 0, 1);
    push(8, 16'd186);
    @(posedge clk); #1 set_in(8, 8'd125, 8'd3, 1, 0, 0, 0);
    @(posedge clk); #1 set_in(8, 8'd125, 8'd3, 0, 0, 0, 0);
    wait_result(8, 7, "w8 load in calc");
    @(posedge clk); #1 set_in(8, 8'd125, 8'd3, 0, 0, 0, 1);
    push(8, 16'd186);
    @(posedge clk); #1 set_in(8, 8'd125, 8'd3, 0, 0, 0, 0);
    wait_result(8, 8, "w8 restart no load");

    // start edge coinciding with load_b in DONE: load applied, start dropped
    @(posedge clk); #1 set_in(8, 8'd125, 8'd5, 0, 1, 0, 1);
    @(posedge clk); #1 set_in(8, 8'd125, 8'd5, 0, 0, 0, 0);
    @(negedge clk);
    chk("w8 start+load done", 32'(bus8.done), 32'd0);
    chk("w8 start+load busy", 32'(bus8.busy), 32'd0);
    chk("w8 start+load p hold", 32'(bus8.p), 32'd186);
    repeat (3) @(negedge clk);
    chk("w8 start dropped", 32'(bus8.busy), 32'd0);
    @(posedge clk); #1 set_in(8, 8'd125, 8'd5, 0, 0, 0, 1);
    push(8, 16'd310);
    @(posedge clk); #1 set_in(8, 8'd125, 8'd5, 0, 0, 0, 0);
    wait_result(8, 8, "w8 62x5");

    // asynchronous reset in the third CALC cycle
    @(posedge clk); #1 set_in(8, 8'd62, 8'd3, 1, 1, 0, 0);
    @(posedge clk); #1 set_in(8, 8'd62, 8'd3, 0, 0, 0, 1);
    @(posedge clk); #1 set_in(8, 8'd62, 8'd3, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk); #1 clrn = 1'b0;
    #1;
    chk("abort p", 32'(bus8.p), 32'd0);
    chk("abort busy", 32'(bus8.busy), 32'd0);
    chk("abort done", 32'(bus8.done), 32'd0);
    set_in(8, 8'd62, 8'd3, 0, 0, 0, 1);
    @(negedge clk);
    clrn = 1'b1;
    push(8, 16'd0);
    @(posedge clk); #1 set_in(8, 8'd62, 8'd3, 0, 0, 0, 0);
    wait_result(8, 8, "w8 after abort");

    repeat (2) @(negedge clk);
    chk("w8 queue drained", 32'(q8.size()), 32'd0);
    chk("w4 queue drained", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
